// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control path: the FSM state
// encoding, opcodes, mux-select encodings and the packed control word.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    EXECUTE  = 4'd6,
    ALUWB    = 4'd7,
    BEQ      = 4'd8,
    ADDIEXEC = 4'd9,
    ADDIWB   = 4'd10,
    JUMP     = 4'd11
  } state_t;

  // Opcodes (instr[31:26])
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // aluop encodings, consumed by the ALU decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // alusrcb encodings
  localparam logic [1:0] SRCB_REGB    = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  // pcsrc encodings
  localparam logic [1:0] PCSRC_ALURES = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Per-state control word; pcwrite/irwrite here are the unqualified
  // FETCH values, the top level gates them with mem_ready.
  typedef struct packed {
    logic       pcwrite;
    logic       branch;
    logic       irwrite;
    logic       memwrite;
    logic       regwrite;
    logic       iord;
    logic       memtoreg;
    logic       regdst;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

endpackage

// File: rtl/mc_ctrl_outdec.sv
// Pure combinational decode from FSM state to the datapath control word.
module mc_ctrl_outdec
  import mips_ctrl_pkg::*;
(
  input  logic [3:0]        i_state,
  output logic [CTRL_W-1:0] o_ctrl
);

  ctrl_t  w_cw;
  state_t w_state;

  assign w_state = state_t'(i_state);
  assign o_ctrl  = w_cw;

  // Moore decode: every field starts at 0 and each state raises only its own.
  always_comb begin
    // NOTE: assigning the whole word first means no path leaves a field
    // unassigned, so no latch can be inferred.
    w_cw = '0;
    case (w_state)
      FETCH: begin
        w_cw.alusrcb = SRCB_FOUR;
        w_cw.irwrite = 1'b1;
        w_cw.pcwrite = 1'b1;
      end
      DECODE: w_cw.alusrcb = SRCB_IMM_SH2;
      MEMADR: begin
        w_cw.alusrca = 1'b1;
        w_cw.alusrcb = SRCB_IMM;
      end
      MEMRD:  w_cw.iord = 1'b1;
      MEMWB: begin
        w_cw.memtoreg = 1'b1;
        w_cw.regwrite = 1'b1;
      end
      MEMWR: begin
        w_cw.iord     = 1'b1;
        w_cw.memwrite = 1'b1;
      end
      EXECUTE: begin
        w_cw.alusrca = 1'b1;
        w_cw.aluop   = ALUOP_FUNCT;
      end
      ALUWB: begin
        w_cw.regdst   = 1'b1;
        w_cw.regwrite = 1'b1;
      end
      BEQ: begin
        w_cw.alusrca = 1'b1;
        w_cw.aluop   = ALUOP_SUB;
        w_cw.pcsrc   = PCSRC_ALUOUT;
        w_cw.branch  = 1'b1;
      end
      ADDIEXEC: begin
        w_cw.alusrca = 1'b1;
        w_cw.alusrcb = SRCB_IMM;
      end
      ADDIWB: w_cw.regwrite = 1'b1;
      JUMP: begin
        w_cw.pcsrc   = PCSRC_JUMP;
        w_cw.pcwrite = 1'b1;
      end
      default: w_cw = '0;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Main control FSM of the multicycle MIPS: state register, next-state
// logic, mem_ready qualification of the FETCH enables and the PC enable.
module mc_ctrl_fsm
  import mips_ctrl_pkg::*;
#(
  parameter int OPW = 6
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [OPW-1:0] op,
  input  logic           zero,
  input  logic           mem_ready,
  output logic           pcen,
  output logic           pcwrite,
  output logic           branch,
  output logic           irwrite,
  output logic           memwrite,
  output logic           regwrite,
  output logic           iord,
  output logic           memtoreg,
  output logic           regdst,
  output logic           alusrca,
  output logic [1:0]     alusrcb,
  output logic [1:0]     pcsrc,
  output logic [1:0]     aluop,
  output logic           illegal
);

  state_t            r_state;
  state_t            w_next;
  logic              w_illegal;
  logic [CTRL_W-1:0] w_ctrl;
  ctrl_t             w_cw;

  // State register; reset abandons any instruction in flight.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignment so every flop
    // samples the pre-edge value regardless of block ordering.
    if (reset) r_state <= FETCH;
    else       r_state <= w_next;
  end

  // Next-state logic plus the illegal-opcode pulse raised in DECODE.
  always_comb begin
    w_next    = FETCH;
    w_illegal = 1'b0;
    case (r_state)
      FETCH:  w_next = mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: w_next = MEMADR;
          OP_RTYPE:     w_next = EXECUTE;
          OP_BEQ:       w_next = BEQ;
          OP_ADDI:      w_next = ADDIEXEC;
          OP_J:         w_next = JUMP;
          default: begin
            w_next    = FETCH;
            w_illegal = 1'b1;
          end
        endcase
      end
      MEMADR:   w_next = (op == OP_SW) ? MEMWR : MEMRD;
      MEMRD:    w_next = mem_ready ? MEMWB : MEMRD;
      MEMWB:    w_next = FETCH;
      MEMWR:    w_next = mem_ready ? FETCH : MEMWR;
      EXECUTE:  w_next = ALUWB;
      ALUWB:    w_next = FETCH;
      BEQ:      w_next = FETCH;
      ADDIEXEC: w_next = ADDIWB;
      ADDIWB:   w_next = FETCH;
      JUMP:     w_next = FETCH;
      default:  w_next = FETCH;
    endcase
  end

  mc_ctrl_outdec u_outdec (
    .i_state (r_state),
    .o_ctrl  (w_ctrl)
  );

  assign w_cw = ctrl_t'(w_ctrl);

  // The IR load and PC increment in FETCH only happen once memory has
  // returned the instruction; JUMP's pcwrite is unconditional.
  assign pcwrite  = w_cw.pcwrite & ((r_state != FETCH) | mem_ready);
  assign irwrite  = w_cw.irwrite & mem_ready;
  assign branch   = w_cw.branch;
  assign memwrite = w_cw.memwrite;
  assign regwrite = w_cw.regwrite;
  assign iord     = w_cw.iord;
  assign memtoreg = w_cw.memtoreg;
  assign regdst   = w_cw.regdst;
  assign alusrca  = w_cw.alusrca;
  assign alusrcb  = w_cw.alusrcb;
  assign pcsrc    = w_cw.pcsrc;
  assign aluop    = w_cw.aluop;
  assign illegal  = w_illegal;

  // Taken branch updates the PC in the same cycle the ALU reports zero.
  assign pcen = pcwrite | (branch & zero);

endmodule

// File: doc/mc_ctrl_fsm.md
# mc_ctrl_fsm

Main control state machine for the multicycle MIPS datapath. It sequences one instruction at a time through fetch, decode, execute, memory and writeback. Each step drives the datapath mux selects and write enables: PC source, ALU operand selects including the shift-left-by-2 branch-offset path, IR/PC/register/memory writes. The ALU function decode stays in the separate ALU decoder, fed by `aluop`. A memory-ready handshake lets the FSM wait on a multicycle memory.

## Interface
- `OPW`, 6, opcode width (instr[31:26])
- `clk` in 1 system clock, rising edge
- `reset` in 1 asynchronous, active-high; forces state FETCH
- `op` in OPW opcode from instruction register
- `zero` in 1 ALU zero flag
- `mem_ready` in 1 memory has completed the current access this cycle
- `pcen` out 1 PC register enable = `pcwrite | (branch & zero)`
- `pcwrite` out 1 unconditional PC write
- `branch` out 1 conditional-branch qualifier
- `irwrite` out 1 instruction register load
- `memwrite` out 1 data memory write strobe
- `regwrite` out 1 register file write
- `iord` out 1 memory address select: 0=PC, 1=ALUOut
- `memtoreg` out 1 writeback data select: 0=ALUOut, 1=Data
- `regdst` out 1 dest register select: 0=rt, 1=rd
- `alusrca` out 1 ALU A select: 0=PC, 1=regA
- `alusrcb` out 2 ALU B select: 00=regB, 01=4, 10=SignImm, 11=SignImm<<2
- `pcsrc` out 2 next-PC select: 00=ALUResult, 01=ALUOut, 10=jump target
- `aluop` out 2 to ALU decoder: 00=add, 01=sub, 10=funct
- `illegal` out 1 one-cycle pulse, unknown opcode decoded

## Operation
- Moore FSM: state register only; all outputs are a combinational decode of state. The only exceptions are `irwrite`/`pcwrite` in FETCH, which are qualified by `mem_ready`, and `pcen`.
- Opcodes: lw 100011, sw 101011, R-type 000000, beq 000100, addi 001000, j 000010.
- Every output not listed for a state is 0.
- FETCH: alusrcb=01. If `mem_ready` is 1: irwrite=1, pcwrite=1, next state is DECODE. Otherwise stay in FETCH with both enables at 0.
- DECODE: alusrcb=11. Branch on `op`:
  - lw/sw go to MEMADR.
  - R-type goes to EXECUTE.
  - beq goes to BEQ.
  - addi goes to ADDIEXEC.
  - j goes to JUMP.
  - Any other opcode: `illegal`=1 this cycle, next state is FETCH.
- MEMADR: alusrca=1, alusrcb=10. Next state is MEMRD for lw, MEMWR for sw.
- MEMRD: iord=1. Stay until `mem_ready`, then go to MEMWB.
- MEMWB: memtoreg=1, regwrite=1, then FETCH.
- MEMWR: iord=1, memwrite=1 held every cycle. Stay until `mem_ready`, then go to FETCH.
- EXECUTE: alusrca=1, aluop=10, then ALUWB.
- ALUWB: regdst=1, regwrite=1, then FETCH.
- BEQ: alusrca=1, aluop=01, pcsrc=01, branch=1, then FETCH.
- ADDIEXEC: alusrca=1, alusrcb=10, then ADDIWB.
- ADDIWB: regwrite=1, then FETCH.
- JUMP: pcsrc=10, pcwrite=1, then FETCH.
- Unreachable state encodings: all outputs 0, next state is FETCH.

## Timing
- State updates on the rising edge of `clk`. `reset` is asynchronous: assertion forces FETCH immediately. Reset mid-instruction abandons that instruction; no regwrite or memwrite is issued after `reset` rises.
- Output values during reset and after release: the FETCH decode, i.e. alusrcb=01. irwrite, pcwrite and pcen follow `mem_ready`. All other outputs are 0.
- `op` is sampled only in DECODE and MEMADR. It is stable because the IR is loaded at the end of FETCH.
- Cycle counts with `mem_ready` held at 1: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
- Each cycle with `mem_ready`=0 in FETCH, MEMRD or MEMWR adds one cycle. There is no timeout.
- `pcen` is combinational, the same cycle as `zero`. A taken beq updates the PC at the end of the BEQ cycle.

## Structure
- Shared package `mips_ctrl_pkg` holds:
  - the state enum: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BEQ, ADDIEXEC, ADDIWB, JUMP;
  - the opcode localparams;
  - the `aluop`, `alusrcb` and `pcsrc` encodings.
- One natural sub-module: `mc_ctrl_outdec`, a pure combinational decode from state to the control word. The top level keeps the state register, next-state logic, `mem_ready` qualification and `pcen`.

## Test plan
- Reset release, `mem_ready`=1, op=100011 (lw): states FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH. regwrite=1 and memtoreg=1 only in cycle 5.
- sw with `mem_ready` low for 3 cycles in MEMWR: memwrite=1 and iord=1 for 4 consecutive cycles, then FETCH. regwrite stays 0 throughout.
- beq with `zero`=1: pcen=1, pcsrc=01, aluop=01 in the BEQ cycle. Repeat with `zero`=0: pcen=0.
- FETCH with `mem_ready`=0 for 2 cycles then 1: irwrite and pcwrite stay 0 for 2 cycles, are 1 in cycle 3, then DECODE.
- op=111111: `illegal` pulses for exactly 1 cycle in DECODE, then FETCH. No write enable is asserted.
- `reset` asserted asynchronously in ALUWB mid-cycle: regwrite drops immediately and the state reads FETCH. After release, an addi completes in 4 cycles.
